// File: rtl/switch_fifo_frame_reader.sv
// Read-side drain engine for the rx switch async FIFO: pops framed words from a
// first-word-fall-through head, enforces frame integrity and emits a registered valid/ready stream.
module switch_fifo_frame_reader #(
  parameter int pDataWidth = 64,
  parameter int pByteWidth = 3,
  parameter int pMaxWords  = 190,
  parameter int pCntWidth  = 16
) (
  input  logic                               iClk,
  input  logic                               iReset,
  input  logic                               iFifoEmpty,
  input  logic [pDataWidth+pByteWidth+1:0]   ivFifoData,
  output logic                               oFifoREn,
  output logic                               oValid,
  input  logic                               iReady,
  output logic [pDataWidth-1:0]              ovData,
  output logic [pByteWidth-1:0]              ovBytes,
  output logic                               oSof,
  output logic                               oEof,
  output logic                               oAbort,
  output logic                               oErr,
  output logic [pCntWidth-1:0]               qvFrameCnt,
  output logic [pCntWidth-1:0]               qvDropCnt
);

  localparam int pWordWidth = pDataWidth + pByteWidth + 2;
  localparam int pWcntWidth = $clog2(pMaxWords + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [pWcntWidth-1:0]   wcnt_q, wcnt_d;
  logic                    valid_q, valid_d;
  logic [pDataWidth-1:0]   data_q, data_d;
  logic [pByteWidth-1:0]   bytes_q, bytes_d;
  logic                    sof_q, sof_d;
  logic                    eof_q, eof_d;
  logic                    abort_q, abort_d;
  logic                    err_q, err_d;
  logic [pCntWidth-1:0]    frame_cnt_q, frame_cnt_d;
  logic [pCntWidth-1:0]    drop_cnt_q, drop_cnt_d;

  logic                    head_sof_s, head_eof_s;
  logic [pByteWidth-1:0]   head_bytes_s;
  logic [pDataWidth-1:0]   head_data_s;
  logic                    free_s, at_max_s, pop_s, load_s, drop_inc_s, frame_inc_s;
  logic                    ld_sof_s, ld_eof_s, ld_abort_s;
  logic [pDataWidth-1:0]   ld_data_s;
  logic [pByteWidth-1:0]   ld_bytes_s;

  assign head_sof_s   = ivFifoData[pWordWidth-1];
  assign head_eof_s   = ivFifoData[pWordWidth-2];
  assign head_bytes_s = ivFifoData[pDataWidth+pByteWidth-1:pDataWidth];
  assign head_data_s  = ivFifoData[pDataWidth-1:0];

  assign free_s      = !valid_q || iReady;
  assign at_max_s    = (wcnt_q == pWcntWidth'(pMaxWords));
  assign frame_inc_s = valid_q && iReady && eof_q && !abort_q;
  assign oFifoREn    = pop_s && !iReset;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    pop_s      = 1'b0;
    load_s     = 1'b0;
    ld_data_s  = head_data_s;
    ld_bytes_s = head_bytes_s;
    ld_sof_s   = 1'b0;
    ld_eof_s   = head_eof_s;
    ld_abort_s = 1'b0;
    err_d      = 1'b0;
    drop_inc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Orphans are discarded even while the output is stalled.
        if (!iFifoEmpty && head_sof_s && free_s) begin
          pop_s    = 1'b1;
          load_s   = 1'b1;
          ld_sof_s = 1'b1;
          if (head_eof_s) begin
            state_d = ST_IDLE;
          end else begin
            wcnt_d  = pWcntWidth'(1);
            state_d = ST_PASS;
          end
        end else if (!iFifoEmpty && !head_sof_s) begin
          pop_s = 1'b1;
          err_d = 1'b1;
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_PASS: begin
        if (!iFifoEmpty && free_s) begin
          if (head_sof_s || (at_max_s && !head_eof_s)) begin
            // Abort terminator; the offending head word stays in the FIFO.
            load_s     = 1'b1;
            ld_data_s  = {pDataWidth{1'b0}};
            ld_bytes_s = {pByteWidth{1'b0}};
            ld_eof_s   = 1'b1;
            ld_abort_s = 1'b1;
            drop_inc_s = 1'b1;
            state_d    = head_sof_s ? ST_IDLE : ST_DROP;
          end else begin
            pop_s  = 1'b1;
            load_s = 1'b1;
            if (head_eof_s) begin
              state_d = ST_IDLE;
            end else begin
              wcnt_d = wcnt_q + pWcntWidth'(1);
            end
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      ST_DROP: begin
        if (!iFifoEmpty && head_sof_s) begin
          state_d = ST_IDLE;
        end else if (!iFifoEmpty) begin
          pop_s = 1'b1;
          if (head_eof_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DROP;
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register: load, drain on acceptance, or hold while stalled.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    bytes_d = bytes_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    abort_d = abort_q;
    if (load_s) begin
      valid_d = 1'b1;
      data_d  = ld_data_s;
      bytes_d = ld_bytes_s;
      sof_d   = ld_sof_s;
      eof_d   = ld_eof_s;
      abort_d = ld_abort_s;
    end else if (free_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Saturating frame and drop counters.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (frame_inc_s && (frame_cnt_q != {pCntWidth{1'b1}})) begin
      frame_cnt_d = frame_cnt_q + pCntWidth'(1);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
    if (drop_inc_s && (drop_cnt_q != {pCntWidth{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + pCntWidth'(1);
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // State, output and counter registers.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= {pWcntWidth{1'b0}};
      valid_q     <= 1'b0;
      data_q      <= {pDataWidth{1'b0}};
      bytes_q     <= {pByteWidth{1'b0}};
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= {pCntWidth{1'b0}};
      drop_cnt_q  <= {pCntWidth{1'b0}};
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      bytes_q     <= bytes_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign oValid     = valid_q;
  assign ovData     = data_q;
  assign ovBytes    = bytes_q;
  assign oSof       = sof_q;
  assign oEof       = eof_q;
  assign oAbort     = abort_q;
  assign oErr       = err_q;
  assign qvFrameCnt = frame_cnt_q;
  assign qvDropCnt  = drop_cnt_q;

endmodule

// File: tb/tb_switch_fifo_frame_reader.sv
// Randomized bench for switch_fifo_frame_reader: a word-level frame parser predicts the
// output stream and counters; a queue stands in for the FIFO.
module tb_switch_fifo_frame_reader;
  localparam int DW = 64;
  localparam int BW = 3;
  localparam int MW = 4;
  localparam int CW = 16;
  localparam int WW = DW + BW + 2;
  localparam int OW = 3 + BW + DW;

  logic          iClk = 1'b0;
  logic          iReset = 1'b1;
  logic          iFifoEmpty = 1'b1;
  logic [WW-1:0] ivFifoData = '0;
  logic          oFifoREn;
  logic          oValid;
  logic          iReady = 1'b0;
  logic [DW-1:0] ovData;
  logic [BW-1:0] ovBytes;
  logic          oSof, oEof, oAbort, oErr;
  logic [CW-1:0] qvFrameCnt, qvDropCnt;

  switch_fifo_frame_reader #(
    .pDataWidth(DW), .pByteWidth(BW), .pMaxWords(MW), .pCntWidth(CW)
  ) dut (
    .iClk(iClk), .iReset(iReset), .iFifoEmpty(iFifoEmpty), .ivFifoData(ivFifoData),
    .oFifoREn(oFifoREn), .oValid(oValid), .iReady(iReady), .ovData(ovData),
    .ovBytes(ovBytes), .oSof(oSof), .oEof(oEof), .oAbort(oAbort), .oErr(oErr),
    .qvFrameCnt(qvFrameCnt), .qvDropCnt(qvDropCnt)
  );

  always #5 iClk = ~iClk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  logic [WW-1:0] fifo_q[$];
  logic [OW-1:0] exp_q[$];
  int  m_mode = 0;   // 0 between frames, 1 inside frame, 2 discarding rest of oversize frame
  int  m_n = 0;
  int  exp_frames = 0, exp_drops = 0, exp_errs = 0, obs_errs = 0;
  int  ready_pct = 10;
  bit  gate_en = 1'b0;
  bit  prev_stall = 1'b0;
  logic [OW-1:0] prev_word = '0;

  function automatic logic [OW-1:0] out_word(input bit sof, input bit eof, input bit abort,
                                             input logic [BW-1:0] bytes, input logic [DW-1:0] data);
    return {sof, eof, abort, (eof ? bytes : {BW{1'b0}}), data};
  endfunction

  // Reference: parse the word sequence into the stream the reader should emit.
  task automatic model_word(input logic [WW-1:0] w);
    bit done = 1'b0;
    bit sof = w[WW-1];
    bit eof = w[WW-2];
    logic [BW-1:0] bytes = w[DW+BW-1:DW];
    logic [DW-1:0] data = w[DW-1:0];
    while (!done) begin
      case (m_mode)
        0: begin
          done = 1'b1;
          if (sof) begin
            exp_q.push_back(out_word(1'b1, eof, 1'b0, bytes, data));
            if (eof) exp_frames++;
            else begin m_mode = 1; m_n = 1; end
          end else begin
            exp_errs++;
          end
        end
        1: begin
          if (sof) begin
            exp_q.push_back(out_word(1'b0, 1'b1, 1'b1, {BW{1'b0}}, {DW{1'b0}}));
            exp_drops++;
            m_mode = 0;
          end else if (m_n == MW && !eof) begin
            exp_q.push_back(out_word(1'b0, 1'b1, 1'b1, {BW{1'b0}}, {DW{1'b0}}));
            exp_drops++;
            m_mode = 2;
            done = 1'b1;
          end else begin
            done = 1'b1;
            exp_q.push_back(out_word(1'b0, eof, 1'b0, bytes, data));
            if (eof) begin exp_frames++; m_mode = 0; end
            else m_n++;
          end
        end
        default: begin
          if (sof) m_mode = 0;
          else begin done = 1'b1; if (eof) m_mode = 0; end
        end
      endcase
    end
  endtask

  task automatic add_word(input bit sof, input bit eof, input logic [BW-1:0] bytes, input logic [DW-1:0] data);
    logic [WW-1:0] w;
    w = {sof, eof, bytes, data};
    fifo_q.push_back(w);
    model_word(w);
  endtask

  task automatic add_frame(input int len, input bit with_eof, input logic [BW-1:0] bytes);
    for (int i = 0; i < len; i++)
      add_word(i == 0, with_eof && (i == len - 1), bytes, {$urandom, $urandom});
  endtask

  task automatic run_cycle();
    logic [OW-1:0] cur;
    bit pop;
    @(negedge iClk);
    iReady = ($urandom_range(0, 9) < ready_pct);
    if (fifo_q.size() > 0 && !(gate_en && $urandom_range(0, 3) == 0)) begin
      iFifoEmpty = 1'b0;
      ivFifoData = fifo_q[0];
    end else begin
      iFifoEmpty = 1'b1;
      ivFifoData = {$urandom, $urandom, $urandom};
    end
    #1;
    check("ren_while_empty", oFifoREn & iFifoEmpty, 1'b0);
    if (oErr) obs_errs++;
    cur = out_word(oSof, oEof, oAbort, ovBytes, ovData);
    if (prev_stall) begin
      check("stall_valid", oValid, 1'b1);
      check("stall_hold", cur, prev_word);
    end
    if (oValid && iReady) begin
      if (exp_q.size() == 0) check("extra_word", oValid, 1'b0);
      else check("out_word", cur, exp_q.pop_front());
    end
    prev_stall = oValid && !iReady;
    prev_word = cur;
    pop = oFifoREn && !iFifoEmpty;
    @(posedge iClk);
    if (pop) void'(fifo_q.pop_front());
  endtask

  task automatic drain_and_check(input string tag);
    int c;
    for (c = 0; c < 20000 && !(fifo_q.size() == 0 && exp_q.size() == 0 && !oValid); c++)
      run_cycle();
    check({tag, "_drain_timeout"}, fifo_q.size() + exp_q.size(), 0);
    for (int i = 0; i < 3; i++) run_cycle();
    check({tag, "_frame_cnt"}, qvFrameCnt, exp_frames);
    check({tag, "_drop_cnt"}, qvDropCnt, exp_drops);
    check({tag, "_err_pulses"}, obs_errs, exp_errs);
  endtask

  initial begin
    // Reset state, with a valid SOF head present.
    iFifoEmpty = 1'b0;
    ivFifoData = {1'b1, 1'b0, 3'd0, 64'h1234};
    iReady = 1'b1;
    #12;
    check("rst_ren", oFifoREn, 1'b0);
    check("rst_valid", oValid, 1'b0);
    check("rst_flags", {oSof, oEof, oAbort, oErr}, 4'd0);
    check("rst_data", {ovBytes, ovData}, '0);
    check("rst_cnts", {qvFrameCnt, qvDropCnt}, '0);
    @(negedge iClk);
    iReset = 1'b0;
    iFifoEmpty = 1'b1;

    // Directed: good 3-word frame, orphan, oversize frame, truncated frame then single-word frame.
    ready_pct = 10;
    gate_en = 1'b0;
    add_word(1'b1, 1'b0, 3'd0, 64'h0D0);
    add_word(1'b0, 1'b0, 3'd0, 64'h0D1);
    add_word(1'b0, 1'b1, 3'd5, 64'h0D2);
    add_word(1'b0, 1'b0, 3'd0, 64'hAA);
    add_frame(6, 1'b1, 3'd2);
    add_word(1'b1, 1'b0, 3'd0, 64'h1D0);
    add_word(1'b0, 1'b0, 3'd0, 64'h1D1);
    add_word(1'b1, 1'b1, 3'd7, 64'hE0);
    add_frame(5, 1'b1, 3'd3);
    drain_and_check("directed");

    // Randomized traffic with backpressure and FIFO bubbles.
    ready_pct = 7;
    gate_en = 1'b1;
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 9) == 0)
        add_word(1'b0, $urandom_range(0, 1) == 1, 3'($urandom), {$urandom, $urandom});
      else
        add_frame($urandom_range(1, 7), $urandom_range(0, 4) != 0, 3'($urandom));
    end
    drain_and_check("random");

    // Asynchronous reset in the middle of a frame.
    ready_pct = 10;
    gate_en = 1'b0;
    add_frame(4, 1'b1, 3'd1);
    run_cycle();
    run_cycle();
    @(negedge iClk);
    iFifoEmpty = 1'b0;
    ivFifoData = {1'b1, 1'b0, 3'd0, 64'h55};
    iReset = 1'b1;
    #1;
    check("mid_rst_valid", oValid, 1'b0);
    check("mid_rst_ren", oFifoREn, 1'b0);
    check("mid_rst_out", {oSof, oEof, oAbort, ovBytes, ovData}, '0);
    check("mid_rst_cnts", {qvFrameCnt, qvDropCnt}, '0);
    fifo_q.delete();
    exp_q.delete();
    m_mode = 0;
    exp_frames = 0; exp_drops = 0; exp_errs = 0; obs_errs = 0;
    prev_stall = 1'b0;
    @(negedge iClk);
    iFifoEmpty = 1'b1;
    iReset = 1'b0;
    add_frame(3, 1'b1, 3'd4);
    drain_and_check("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
